// File: rtl/msrr_pkg.sv
// Shared types and constants for the msrr shift/rotate sequencer.
// MSRR_SEQ_ROT2_EN selects double-step (sel=10) rotations in the helpers below.
package msrr_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        ROT,
        DONE
    } state_t;

    localparam logic [1:0] SEL_HOLD  = 2'b00;
    localparam logic [1:0] SEL_ROR1  = 2'b01;
    localparam logic [1:0] SEL_ROR2  = 2'b10;
    localparam logic [1:0] SEL_SHIFT = 2'b11;

    typedef enum logic [2:0] {
        CNT_HOLD,
        CNT_CLEAR,
        CNT_INC,
        CNT_LOAD,
        CNT_DEC1,
        CNT_DEC2
    } cnt_op_t;

    // Datapath select for a ROT cycle that starts with rem steps outstanding.
    function automatic logic [1:0] rot_sel(input logic [3:0] rem);
`ifdef MSRR_SEQ_ROT2_EN
        return (rem >= 4'd2) ? SEL_ROR2 : SEL_ROR1;
`else
        return (rem != 4'd0) ? SEL_ROR1 : SEL_HOLD;
`endif
    endfunction

    function automatic logic [3:0] rot_step(input logic [3:0] rem);
`ifdef MSRR_SEQ_ROT2_EN
        return (rem >= 4'd2) ? 4'd2 : 4'd1;
`else
        return (rem != 4'd0) ? 4'd1 : 4'd0;
`endif
    endfunction

endpackage

// File: rtl/msrr_if.sv
// Command handshake plus datapath control/feedback bundle for msrr_sequencer.
interface msrr_if;
    logic       start;
    logic [7:0] din;
    logic [2:0] rot_amt;
    logic [7:0] po;
    logic [1:0] sel;
    logic       sin;
    logic       ready;
    logic       done;
    logic [7:0] result;

    modport slave (
        input  start, din, rot_amt, po,
        output sel, sin, ready, done, result
    );

    modport master (
        output start, din, rot_amt, po,
        input  sel, sin, ready, done, result
    );
endinterface

// File: rtl/msrr_step_cnt.sv
// 4-bit step counter shared by the LOAD bit index and the ROT remaining count.
module msrr_step_cnt
    import msrr_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  cnt_op_t    op,
    input  logic [3:0] load_val,
    output logic [3:0] cnt,
    output logic       zero
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= 4'd0;
        end else begin
            case (op)
                CNT_CLEAR: cnt <= 4'd0;
                CNT_INC:   cnt <= cnt + 4'd1;
                CNT_LOAD:  cnt <= load_val;
                CNT_DEC1:  cnt <= cnt - 4'd1;
                CNT_DEC2:  cnt <= cnt - 4'd2;
                default:   cnt <= cnt;
            endcase
        end
    end

    assign zero = (cnt == 4'd0);

endmodule

// File: rtl/msrr_sequencer.sv
// Sequencer that serially loads a byte into an 8-bit shift/rotate register, then rotates it right.
// Define MSRR_SEQ_ROT2_EN to allow double-step (sel=10) rotations.
module msrr_sequencer
    import msrr_pkg::*;
#(
    parameter int NBITS = 8
) (
    input  logic  clk,
    input  logic  rst,
    msrr_if.slave bus
);

    generate
        if (NBITS != 8) begin : g_bad_nbits
            $error("msrr_sequencer supports NBITS=8 only");
        end
    endgenerate

    state_t     state;
    logic [7:0] din_q;
    logic [2:0] amt_q;
    logic [1:0] sel_q;
    logic       sin_q;
    logic       done_q;
    logic [7:0] result_q;
    logic [3:0] cnt;
    logic       cnt_zero;
    cnt_op_t    cnt_op;
    logic [3:0] rem_next;

    assign rem_next = cnt - rot_step(cnt);

    always_comb begin
        cnt_op = CNT_HOLD;
        case (state)
            IDLE:    cnt_op = bus.start ? CNT_CLEAR : CNT_HOLD;
            LOAD:    cnt_op = (cnt == 4'd7) ? CNT_LOAD : CNT_INC;
            ROT:     cnt_op = (rot_step(cnt) == 4'd2) ? CNT_DEC2 : CNT_DEC1;
            default: cnt_op = CNT_HOLD;
        endcase
    end

    msrr_step_cnt u_cnt (
        .clk      (clk),
        .rst      (rst),
        .op       (cnt_op),
        .load_val ({1'b0, amt_q}),
        .cnt      (cnt),
        .zero     (cnt_zero)
    );

    // sel/sin are set for the state being entered, so they never depend on start combinationally.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            din_q    <= 8'h00;
            amt_q    <= 3'd0;
            sel_q    <= SEL_HOLD;
            sin_q    <= 1'b0;
            done_q   <= 1'b0;
            result_q <= 8'h00;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state <= LOAD;
                        din_q <= bus.din;
                        amt_q <= bus.rot_amt;
                        sel_q <= SEL_SHIFT;
                        sin_q <= bus.din[0];
                    end
                end
                LOAD: begin
                    if (cnt == 4'd7) begin
                        sin_q <= 1'b0;
                        if (amt_q != 3'd0) begin
                            state <= ROT;
                            sel_q <= rot_sel({1'b0, amt_q});
                        end else begin
                            state <= DONE;
                            sel_q <= SEL_HOLD;
                        end
                    end else begin
                        sin_q <= din_q[cnt[2:0] + 3'd1];
                    end
                end
                ROT: begin
                    if (cnt_zero || rem_next == 4'd0) begin
                        state <= DONE;
                        sel_q <= SEL_HOLD;
                    end else begin
                        sel_q <= rot_sel(rem_next);
                    end
                end
                DONE: begin
                    state    <= IDLE;
                    sel_q    <= SEL_HOLD;
                    done_q   <= 1'b1;
                    result_q <= bus.po;
                end
                default: begin
                    state <= IDLE;
                    sel_q <= SEL_HOLD;
                    sin_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.sel    = sel_q;
    assign bus.sin    = sin_q;
    assign bus.done   = done_q;
    assign bus.result = result_q;
    assign bus.ready  = (state == IDLE);

endmodule

// File: tb/tb_msrr_sequencer.sv
// Self-checking bench for msrr_sequencer driving a behavioural 8-bit shift/rotate register.
module tb_msrr_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b0;

    msrr_if bus ();

    msrr_sequencer #(.NBITS(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // The existing shift/rotate register: 00 hold, 01 ror1, 10 ror2, 11 shift right with sin into bit 7.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.po <= 8'h00;
        end else begin
            case (bus.sel)
                2'b01:   bus.po <= {bus.po[0], bus.po[7:1]};
                2'b10:   bus.po <= {bus.po[1:0], bus.po[7:2]};
                2'b11:   bus.po <= {bus.sin, bus.po[7:1]};
                default: bus.po <= bus.po;
            endcase
        end
    end

    typedef struct {
        logic [7:0] din;
        logic [2:0] amt;
        logic [7:0] res;
    } vec_t;

    typedef struct {
        logic [7:0] res;
        int         lat;
    } exp_t;

    int   nAssert = 0;
    int   nFail   = 0;
    exp_t sb[$];
    vec_t vecs[7];
    logic prevDone = 1'b0;

    function automatic logic [7:0] ror8(input logic [7:0] x, input int n);
        logic [15:0] w;
        w = {x, x} >> n;
        return w[7:0];
    endfunction

    function automatic int rotCycles(input int amt);
`ifdef MSRR_SEQ_ROT2_EN
        return (amt + 1) / 2;
`else
        return amt;
`endif
    endfunction

    task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
        nAssert++;
        if (act !== exp) begin
            nFail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Called on a falling edge; returns on the falling edge just after the accepting edge.
    task automatic applyStimulus(input logic [7:0] d, input logic [2:0] a,
                                 input logic [7:0] expRes, input int expLat, input bit hold);
        int w = 0;
        while (!bus.ready && w < 40) begin
            @(negedge clk);
            w++;
        end
        if (!bus.ready) begin
            nAssert++;
            nFail++;
            $display("[TB] FAIL ready_wait: ready still 0 after %0d cycles, expected 1", w);
        end
        bus.din     = d;
        bus.rot_amt = a;
        bus.start   = 1'b1;
        sb.push_back('{expRes, expLat});
        @(posedge clk);
        @(negedge clk);
        if (!hold) bus.start = 1'b0;
    endtask

    // k0 = edges already elapsed since the accepting edge.
    task automatic checkOutput(input int k0);
        int   k = k0;
        exp_t e;
        while (!bus.done && k < 40) begin
            @(negedge clk);
            k++;
        end
        if (sb.size() == 0) begin
            nAssert++;
            nFail++;
            $display("[TB] FAIL scoreboard: got empty queue, expected an entry");
        end else begin
            e = sb.pop_front();
            compare("done_seen", {31'd0, bus.done}, 32'd1);
            compare("latency", k, e.lat);
            compare("result", {24'd0, bus.result}, {24'd0, e.res});
        end
    endtask

    // Continuous protocol checks on every cycle out of reset.
    always @(negedge clk) begin
        if (rst) begin
            nAssert++;
            if (bus.sel != 2'b11 && bus.sin !== 1'b0) begin
                nFail++;
                $display("[TB] FAIL sin_outside_load: got sin=%0b with sel=%0b, expected 0", bus.sin, bus.sel);
            end
            nAssert++;
            if (bus.done && !bus.ready) begin
                nFail++;
                $display("[TB] FAIL done_ready: got ready=0 during done, expected 1");
            end
            nAssert++;
            if (prevDone && bus.done) begin
                nFail++;
                $display("[TB] FAIL done_width: got done high 2 cycles, expected 1");
            end
`ifndef MSRR_SEQ_ROT2_EN
            nAssert++;
            if (bus.sel == 2'b10) begin
                nFail++;
                $display("[TB] FAIL no_ror2: got sel=10, expected never without double-step");
            end
`endif
            prevDone = bus.done;
        end else begin
            prevDone = 1'b0;
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: got no finish, expected finish before 200000");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        logic [7:0] pat;
        logic [1:0] expSel[7];
        bit         sawDone;
        exp_t       drop;

        vecs[0] = '{8'hA5, 3'd0, 8'hA5};
        vecs[1] = '{8'h81, 3'd3, 8'h30};
        vecs[2] = '{8'h01, 3'd7, 8'h02};
        vecs[3] = '{8'h3C, 3'd1, ror8(8'h3C, 1)};
        vecs[4] = '{8'hF0, 3'd4, ror8(8'hF0, 4)};
        vecs[5] = '{8'h96, 3'd5, ror8(8'h96, 5)};
        vecs[6] = '{8'h5A, 3'd6, ror8(8'h5A, 6)};

        bus.start   = 1'b0;
        bus.din     = 8'h00;
        bus.rot_amt = 3'd0;
        rst         = 1'b0;

        repeat (2) @(negedge clk);
        compare("rst_sel", {30'd0, bus.sel}, 32'd0);
        compare("rst_sin", {31'd0, bus.sin}, 32'd0);
        compare("rst_ready", {31'd0, bus.ready}, 32'd1);
        compare("rst_done", {31'd0, bus.done}, 32'd0);
        compare("rst_result", {24'd0, bus.result}, 32'd0);
        rst = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            applyStimulus(vecs[i].din, vecs[i].amt, vecs[i].res, 9 + rotCycles(vecs[i].amt), 1'b0);
            checkOutput(0);
            @(negedge clk);
        end

        // Serial load order: LSB first with sel=11.
        pat = 8'hA5;
        applyStimulus(pat, 3'd0, 8'hA5, 9, 1'b0);
        for (int k = 0; k < 8; k++) begin
            compare($sformatf("load_sel_%0d", k), {30'd0, bus.sel}, 32'd3);
            compare($sformatf("load_sin_%0d", k), {31'd0, bus.sin}, {31'd0, pat[k]});
            @(negedge clk);
        end
        checkOutput(8);
        @(negedge clk);

        // Rotation select sequence for a 7-step rotate.
`ifdef MSRR_SEQ_ROT2_EN
        expSel = '{2'b10, 2'b10, 2'b10, 2'b01, 2'b00, 2'b00, 2'b00};
`else
        expSel = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01};
`endif
        applyStimulus(8'h01, 3'd7, 8'h02, 9 + rotCycles(7), 1'b0);
        repeat (8) @(negedge clk);
        for (int j = 0; j < rotCycles(7); j++) begin
            compare($sformatf("rot_sel_%0d", j), {30'd0, bus.sel}, {30'd0, expSel[j]});
            @(negedge clk);
        end
        checkOutput(8 + rotCycles(7));
        @(negedge clk);

        // A start pulse while busy must not disturb the running command.
        applyStimulus(8'h81, 3'd3, 8'h30, 9 + rotCycles(3), 1'b0);
        bus.din     = 8'hFF;
        bus.rot_amt = 3'd7;
        bus.start   = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        checkOutput(1);
        @(negedge clk);

        // Reset in LOAD cycle 4 aborts the command immediately.
        applyStimulus(8'hA5, 3'd2, 8'h00, 0, 1'b0);
        repeat (4) @(negedge clk);
        #1 rst = 1'b0;
        #1;
        compare("abort_sel", {30'd0, bus.sel}, 32'd0);
        compare("abort_sin", {31'd0, bus.sin}, 32'd0);
        compare("abort_ready", {31'd0, bus.ready}, 32'd1);
        compare("abort_result", {24'd0, bus.result}, 32'd0);
        compare("abort_done", {31'd0, bus.done}, 32'd0);
        drop = sb.pop_front();
        @(negedge clk);
        rst = 1'b1;
        sawDone = 1'b0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            if (bus.done) sawDone = 1'b1;
        end
        compare("abort_no_done", {31'd0, sawDone}, 32'd0);
        applyStimulus(8'h81, 3'd3, 8'h30, 9 + rotCycles(3), 1'b0);
        checkOutput(0);
        @(negedge clk);

        // start held across done: the second command is accepted on the done cycle.
        applyStimulus(8'hA5, 3'd0, 8'hA5, 9, 1'b1);
        bus.din     = 8'h3C;
        bus.rot_amt = 3'd1;
        checkOutput(0);
        sb.push_back('{ror8(8'h3C, 1), 9 + rotCycles(1)});
        @(posedge clk);
        @(negedge clk);
        compare("b2b_no_gap", {31'd0, bus.ready}, 32'd0);
        bus.start = 1'b0;
        checkOutput(0);

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
        $finish;
    end

endmodule

// File: doc/msrr_sequencer.md
MSRR_SEQUENCER -- requirements
Module: msrr_sequencer

Interface
REQ-001 Parameter NBITS, default 8: width of the controlled shift/rotate register; only 8 is supported, and other values shall fail elaboration.
REQ-002 clk  in  1  sole clock; all state updates on the rising edge.
REQ-003 rst  in  1  asynchronous, active-low reset.
REQ-004 start  in  1  command request; accepted on an edge where start=1 and ready=1.
REQ-005 din  in  8  byte to load into the datapath, sampled on acceptance.
REQ-006 rot_amt  in  3  rotate-right amount 0..7, sampled on acceptance.
REQ-007 po  in  8  datapath parallel output, fed back.
REQ-008 sel  out  2  datapath select: 00 hold, 01 rotate right by 1, 10 rotate right by 2, 11 shift right with sin entering bit 7.
REQ-009 sin  out  1  datapath serial input.
REQ-010 ready  out  1  high only in IDLE.
REQ-011 done  out  1  registered one-cycle pulse marking command completion.
REQ-012 result  out  8  registered final datapath value; holds until the next completion.

Function
REQ-013 States shall be IDLE, LOAD, ROT and DONE; sel shall be 00 in IDLE and DONE.
REQ-014 IDLE -> LOAD on acceptance; din and rot_amt are captured into din_q and amt_q, and the step counter is cleared.
REQ-015 In LOAD cycle i (i=0..7): sel=11 and sin=din_q[i], LSB first; after 8 edges po equals din_q.
REQ-016 LOAD exit: go to ROT if amt_q!=0, otherwise go to DONE.
REQ-017 ROT (MSRR_SEQ_ROT2_EN defined): sel=10 while remaining>=2 (remaining -= 2); sel=01 when remaining==1; go to DONE when remaining reaches 0.
REQ-018 ROT cycle count R: ceil(amt_q/2) with the macro, amt_q without it.
REQ-019 DONE lasts 1 cycle, then returns to IDLE; on that edge result<=po and done<=1.
REQ-020 done is high for exactly the one cycle following DONE, coincident with ready=1.
REQ-021 Latency: done rises 8+R+1 edges after the accepting edge.
REQ-022 start while ready=0 shall be ignored; no queueing.
REQ-023 A start in the same cycle as done=1 shall be accepted, giving back-to-back commands.
REQ-024 sin shall be 0 outside LOAD.
REQ-025 sel and sin shall decode from registered state only, with no combinational path from start.

Reset
REQ-026 rst=0 shall force IDLE immediately; sel=00, sin=0, done=0, result=8'h00, ready=1, and the counter and captured registers cleared.
REQ-027 Reset mid-LOAD or mid-ROT shall abort the command without producing a done pulse; the datapath shares rst and is cleared with it.

Configuration
REQ-028 Macro MSRR_SEQ_ROT2_EN: when defined, the sequencer uses sel=10 double-step rotations; when undefined, only sel=01 single steps are used and sel=10 is never driven.

Structure
REQ-029 Package msrr_pkg shall hold the state enum (IDLE, LOAD, ROT, DONE) and the select constants SEL_HOLD, SEL_ROR1, SEL_ROR2 and SEL_SHIFT.
REQ-030 One sub-module, msrr_step_cnt: a 4-bit counter with clear, decrement-by-1/2 and zero flag, serving both the LOAD index and the ROT remaining count.
REQ-031 The bench shall instantiate msrr_sequencer connected to the existing 8-bit shift/rotate register (sel, Sin, clk, rst, Po).

Verification
REQ-032 din=8'hA5, rot_amt=0 -> 8 cycles of sel=11 with sin=1,0,1,0,0,1,0,1, no ROT, then done at edge 9 with result=8'hA5.
REQ-033 din=8'h81, rot_amt=3 -> result=8'h30; R=2 (sel 10 then 01) with the macro, R=3 without it.
REQ-034 din=8'h01, rot_amt=7 -> result=8'h02; done at edge 13 with the macro (sel 10,10,10,01), at edge 16 without it.
REQ-035 start pulsed during LOAD with din=8'hFF -> ignored; the original command completes unchanged.
REQ-036 rst low at LOAD cycle 4 -> sel=00, ready=1, result=8'h00 asynchronously, no done pulse; a new command then completes normally.
REQ-037 start held high across done -> second command accepted on the done cycle, with no idle gap.
